// File: rtl/biquad_coeff_loader_pkg.sv
// Shared types and constants for the biquad coefficient loader: coefficient
// width, FSM state encoding and an index-width helper.
package biquad_coeff_loader_pkg;

  localparam int COEFF_BITS = 18;
  localparam int GAP_BITS   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_GAP    = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Bits needed to index n entries, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/biquad_coeff_loader_shadow.sv
// Host-written shadow copy of the coefficients: NCOEFF x COEFF_BITS register
// file, one write port, combinational read port.
module biquad_coeff_loader_shadow
  import biquad_coeff_loader_pkg::*;
#(
  parameter int NCOEFF   = 4,
  parameter int ADDRBITS = 2,
  parameter int IDXBITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDRBITS-1:0]   i_wr_addr,
  input  logic [COEFF_BITS-1:0] i_wr_dat,
  input  logic [IDXBITS-1:0]    i_rd_idx,
  output logic [COEFF_BITS-1:0] o_rd_dat
);

  logic [COEFF_BITS-1:0] r_mem [NCOEFF];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCOEFF; k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_wr_en) begin
      for (int k = 0; k < NCOEFF; k++) begin
        if (i_wr_addr == ADDRBITS'(k)) begin
          r_mem[k] <= i_wr_dat;
        end
      end
    end
  end

  always_comb begin
    o_rd_dat = '0;
    for (int k = 0; k < NCOEFF; k++) begin
      o_rd_dat = (i_rd_idx == IDXBITS'(k)) ? r_mem[k] : o_rd_dat;
    end
  end

endmodule

// File: rtl/biquad_coeff_loader.sv
// Writer side of the biquad DSP coefficient-load interface: shifts the shadow
// coefficients into the B-cascade (last index first) and then commits them.
module biquad_coeff_loader
  import biquad_coeff_loader_pkg::*;
#(
  parameter int NCOEFF   = 4,
  parameter int ADDRBITS = 2,
  parameter int WR_GAP   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr_i,
  input  logic [ADDRBITS-1:0]   cfg_addr_i,
  input  logic [COEFF_BITS-1:0] cfg_dat_i,
  input  logic                  cfg_load_i,
  output logic                  cfg_busy_o,
  output logic                  cfg_done_o,
  output logic                  cfg_err_o,
  output logic [COEFF_BITS-1:0] coeff_dat_o,
  output logic                  coeff_wr_o,
  output logic                  coeff_update_o
);

  localparam int IDXBITS = clog2_min1(NCOEFF);
  localparam int AW1     = ADDRBITS + 1;
  localparam logic [IDXBITS-1:0]  IDX_LAST   = IDXBITS'(NCOEFF - 1);
  localparam logic [AW1-1:0]      ADDR_LIMIT = AW1'(NCOEFF);
  localparam logic [GAP_BITS-1:0] GAP_LAST   = (WR_GAP > 0) ? GAP_BITS'(WR_GAP - 1) : '0;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDXBITS-1:0]    r_idx;
  logic [IDXBITS-1:0]    w_idx_nxt;
  logic [GAP_BITS-1:0]   r_gap_cnt;
  logic [GAP_BITS-1:0]   w_gap_nxt;

  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [COEFF_BITS-1:0] r_coeff_dat;
  logic                  r_coeff_wr;
  logic                  r_coeff_update;

  logic                  w_idle;
  logic                  w_addr_ok;
  logic                  w_wr_ok;
  logic                  w_load_ok;
  logic                  w_err_evt;
  logic                  w_bypass;
  logic [COEFF_BITS-1:0] w_rd_dat;
  logic [COEFF_BITS-1:0] w_shift_dat;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_addr_ok = ({1'b0, cfg_addr_i} < ADDR_LIMIT);
  assign w_wr_ok   = w_idle & cfg_wr_i & w_addr_ok;
  assign w_load_ok = w_idle & cfg_load_i;
  assign w_err_evt = (cfg_wr_i & ~(w_idle & w_addr_ok)) | (cfg_load_i & ~w_idle);

  biquad_coeff_loader_shadow #(
    .NCOEFF   (NCOEFF),
    .ADDRBITS (ADDRBITS),
    .IDXBITS  (IDXBITS)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (cfg_addr_i),
    .i_wr_dat  (cfg_dat_i),
    .i_rd_idx  (w_idx_nxt),
    .o_rd_dat  (w_rd_dat)
  );

  // A write landing in the load cycle must be the value that gets shifted.
  assign w_bypass    = w_wr_ok && (cfg_addr_i == ADDRBITS'(w_idx_nxt));
  assign w_shift_dat = w_bypass ? cfg_dat_i : w_rd_dat;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap_cnt;
    case (r_state)
      ST_IDLE: begin
        if (cfg_load_i) begin
          w_state_nxt = ST_SHIFT;
          w_idx_nxt   = IDX_LAST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_idx == '0) begin
          w_state_nxt = ST_UPDATE;
        end else begin
          w_idx_nxt = r_idx - IDXBITS'(1);
          if (WR_GAP > 0) begin
            w_state_nxt = ST_GAP;
            w_gap_nxt   = '0;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_gap_nxt = r_gap_cnt + GAP_BITS'(1);
        end
      end
      ST_UPDATE: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_gap_cnt      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_coeff_dat    <= '0;
      r_coeff_wr     <= 1'b0;
      r_coeff_update <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_gap_cnt      <= w_gap_nxt;
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_done         <= (w_state_nxt == ST_DONE);
      r_coeff_update <= (w_state_nxt == ST_UPDATE);
      r_coeff_wr     <= (w_state_nxt == ST_SHIFT);
      r_err          <= (r_err & ~w_load_ok) | w_err_evt;
      if (w_state_nxt == ST_SHIFT) begin
        r_coeff_dat <= w_shift_dat;
      end
    end
  end

  assign cfg_busy_o     = r_busy;
  assign cfg_done_o     = r_done;
  assign cfg_err_o      = r_err;
  assign coeff_dat_o    = r_coeff_dat;
  assign coeff_wr_o     = r_coeff_wr;
  assign coeff_update_o = r_coeff_update;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Self-checking bench for biquad_coeff_loader: three instances (N4/gap0,
// N4/gap2, N3/gap0) share one stimulus stream.
module tb_biquad_coeff_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic        cfg_load;
  logic [1:0]  cfg_addr;
  logic [17:0] cfg_dat;

  logic        a_busy, a_done, a_err, a_wr, a_upd;
  logic        b_busy, b_done, b_err, b_wr, b_upd;
  logic        c_busy, c_done, c_err, c_wr, c_upd;
  logic [17:0] a_dat, b_dat, c_dat;

  logic [2:0]  o_busy, o_done, o_err, o_wr, o_upd;
  logic [17:0] o_dat [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  biquad_coeff_loader #(.NCOEFF(4), .ADDRBITS(2), .WR_GAP(0)) u_a (
    .clk(clk), .rst(rst), .cfg_wr_i(cfg_wr), .cfg_addr_i(cfg_addr), .cfg_dat_i(cfg_dat),
    .cfg_load_i(cfg_load), .cfg_busy_o(a_busy), .cfg_done_o(a_done), .cfg_err_o(a_err),
    .coeff_dat_o(a_dat), .coeff_wr_o(a_wr), .coeff_update_o(a_upd));

  biquad_coeff_loader #(.NCOEFF(4), .ADDRBITS(2), .WR_GAP(2)) u_b (
    .clk(clk), .rst(rst), .cfg_wr_i(cfg_wr), .cfg_addr_i(cfg_addr), .cfg_dat_i(cfg_dat),
    .cfg_load_i(cfg_load), .cfg_busy_o(b_busy), .cfg_done_o(b_done), .cfg_err_o(b_err),
    .coeff_dat_o(b_dat), .coeff_wr_o(b_wr), .coeff_update_o(b_upd));

  biquad_coeff_loader #(.NCOEFF(3), .ADDRBITS(2), .WR_GAP(0)) u_c (
    .clk(clk), .rst(rst), .cfg_wr_i(cfg_wr), .cfg_addr_i(cfg_addr), .cfg_dat_i(cfg_dat),
    .cfg_load_i(cfg_load), .cfg_busy_o(c_busy), .cfg_done_o(c_done), .cfg_err_o(c_err),
    .coeff_dat_o(c_dat), .coeff_wr_o(c_wr), .coeff_update_o(c_upd));

  assign o_busy = {c_busy, b_busy, a_busy};
  assign o_done = {c_done, b_done, a_done};
  assign o_err  = {c_err,  b_err,  a_err};
  assign o_wr   = {c_wr,   b_wr,   a_wr};
  assign o_upd  = {c_upd,  b_upd,  a_upd};
  assign o_dat[0] = a_dat;
  assign o_dat[1] = b_dat;
  assign o_dat[2] = c_dat;

  // B-cascade model for instance A: words enter DSP0 and move toward DSP3.
  logic [17:0] chain [4] = '{default: 18'h0};
  logic [17:0] live  [4] = '{default: 18'h0};
  always @(posedge clk) begin
    if (a_wr) begin
      chain[3] <= chain[2];
      chain[2] <= chain[1];
      chain[1] <= chain[0];
      chain[0] <= a_dat;
    end
    if (a_upd) begin
      for (int k = 0; k < 4; k++) live[k] <= chain[k];
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [17:0] dat;
    logic        load;
    logic        e_wr;
    logic [17:0] e_dat;
    logic        e_upd;
    logic        e_done;
    logic        e_busy;
    logic        e_err;
  } vec_t;
  vec_t tbl [11];

  int          wr_cnt [3];
  int          upd_cnt [3];
  int          done_cnt [3];
  int          upd_at [3];
  int          done_at [3];
  int          busy_len [3];
  int          wr_at [3][16];
  logic [17:0] words [3][16];
  logic [2:0]  err_c1;
  logic [2:0]  err_end;
  logic [2:0]  zero_ok;
  logic [17:0] exp_live [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_load(input logic with_wr, input logic [1:0] a, input logic [17:0] v);
    cfg_wr   = with_wr;
    cfg_addr = a;
    cfg_dat  = v;
    cfg_load = 1'b1;
    step();
    cfg_wr   = 1'b0;
    cfg_load = 1'b0;
  endtask

  // Observe ncyc cycles after a load; optionally inject a write+load or a reset.
  task automatic watch(input int ncyc, input int inj_at, input int rst_at);
    for (int d = 0; d < 3; d++) begin
      wr_cnt[d] = 0; upd_cnt[d] = 0; done_cnt[d] = 0;
      upd_at[d] = 0; done_at[d] = 0; busy_len[d] = 0;
    end
    zero_ok = 3'b000;
    for (int c = 1; c <= ncyc; c++) begin
      for (int d = 0; d < 3; d++) begin
        if (o_wr[d]) begin
          if (wr_cnt[d] < 16) begin
            words[d][wr_cnt[d]] = o_dat[d];
            wr_at[d][wr_cnt[d]] = c;
          end
          wr_cnt[d]++;
        end
        if (o_upd[d])  begin upd_cnt[d]++;  upd_at[d]  = c; end
        if (o_done[d]) begin done_cnt[d]++; done_at[d] = c; end
        if (o_busy[d]) busy_len[d]++;
        if (c == 1)    err_c1[d]  = o_err[d];
        if (c == ncyc) err_end[d] = o_err[d];
        if (c == rst_at + 1)
          zero_ok[d] = !(o_wr[d] | o_upd[d] | o_done[d] | o_busy[d] | o_err[d]) && (o_dat[d] == 18'h0);
      end
      rst      = (c == rst_at);
      cfg_wr   = (c == inj_at);
      cfg_load = (c == inj_at);
      cfg_addr = 2'd2;
      cfg_dat  = 18'h0AAAA;
      step();
    end
    rst      = 1'b0;
    cfg_wr   = 1'b0;
    cfg_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_load = 1'b0; cfg_addr = 2'd0; cfg_dat = 18'h0;

    tbl[0]  = '{1'b1, 2'd0, 18'h00001, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 18'h00002, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 18'h00003, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd3, 18'h3FFFF, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 18'h00000, 1'b1, 1'b1, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 18'h00000, 1'b0, 1'b1, 18'h00003, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 18'h00000, 1'b0, 1'b1, 18'h00002, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 18'h00000, 1'b0, 1'b1, 18'h00001, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 18'h00000, 1'b0, 1'b0, 18'h00001, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 18'h00000, 1'b0, 1'b0, 18'h00001, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 18'h00000, 1'b0, 1'b0, 18'h00001, 1'b0, 1'b0, 1'b0, 1'b0};

    step();
    step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d.busy", d), o_busy[d], 1'b0);
      chk($sformatf("rst%0d.done", d), o_done[d], 1'b0);
      chk($sformatf("rst%0d.err",  d), o_err[d],  1'b0);
      chk($sformatf("rst%0d.wr",   d), o_wr[d],   1'b0);
      chk($sformatf("rst%0d.upd",  d), o_upd[d],  1'b0);
      chk($sformatf("rst%0d.dat",  d), o_dat[d],  18'h0);
    end
    rst = 1'b0;

    // Basic load timing on instance A, one row per cycle.
    for (int i = 0; i < 11; i++) begin
      cfg_wr = tbl[i].wr; cfg_addr = tbl[i].addr; cfg_dat = tbl[i].dat; cfg_load = tbl[i].load;
      step();
      chk($sformatf("t1[%0d].wr",   i), a_wr,   tbl[i].e_wr);
      chk($sformatf("t1[%0d].dat",  i), a_dat,  tbl[i].e_dat);
      chk($sformatf("t1[%0d].upd",  i), a_upd,  tbl[i].e_upd);
      chk($sformatf("t1[%0d].done", i), a_done, tbl[i].e_done);
      chk($sformatf("t1[%0d].busy", i), a_busy, tbl[i].e_busy);
      chk($sformatf("t1[%0d].err",  i), a_err,  tbl[i].e_err);
    end
    cfg_wr = 1'b0; cfg_load = 1'b0;
    exp_live[0] = 18'h00001; exp_live[1] = 18'h00002; exp_live[2] = 18'h00003; exp_live[3] = 18'h3FFFF;
    for (int k = 0; k < 4; k++) chk($sformatf("t1.dsp%0d", k), live[k], exp_live[k]);
    repeat (8) step();

    // WR_GAP=2 spacing on instance B.
    issue_load(1'b0, 2'd0, 18'h0);
    watch(16, -1, -1);
    chk("t2.wr_cnt", wr_cnt[1], 4);
    chk("t2.wr_at0", wr_at[1][0], 1);
    chk("t2.wr_at1", wr_at[1][1], 4);
    chk("t2.wr_at2", wr_at[1][2], 7);
    chk("t2.wr_at3", wr_at[1][3], 10);
    chk("t2.word0",  words[1][0], 18'h3FFFF);
    chk("t2.word3",  words[1][3], 18'h00001);
    chk("t2.upd_cnt", upd_cnt[1], 1);
    chk("t2.upd_at", upd_at[1], 11);
    chk("t2.done_cnt", done_cnt[1], 1);
    chk("t2.done_at", done_at[1], 12);
    chk("t2.busy_len", busy_len[1], 12);
    chk("t2.a_busy_len", busy_len[0], 6);

    // Same-cycle write and load: new value goes out first.
    issue_load(1'b1, 2'd3, 18'h12345);
    watch(16, -1, -1);
    chk("t3.word0", words[0][0], 18'h12345);
    chk("t3.wr_cnt", wr_cnt[0], 4);
    chk("t3.err_c1", err_c1[0], 1'b0);
    chk("t3.err_end", err_end[0], 1'b0);

    // Write and load while busy are dropped and flag an error.
    issue_load(1'b0, 2'd0, 18'h0);
    watch(16, 2, -1);
    chk("t4.wr_cnt", wr_cnt[0], 4);
    chk("t4.word0", words[0][0], 18'h12345);
    chk("t4.word1", words[0][1], 18'h00003);
    chk("t4.upd_cnt", upd_cnt[0], 1);
    chk("t4.done_cnt", done_cnt[0], 1);
    chk("t4.err_c1", err_c1[0], 1'b0);
    chk("t4.err_end", err_end[0], 1'b1);
    exp_live[3] = 18'h12345;
    for (int k = 0; k < 4; k++) chk($sformatf("t4.dsp%0d", k), live[k], exp_live[k]);
    issue_load(1'b0, 2'd0, 18'h0);
    watch(16, -1, -1);
    chk("t4.reload_err", err_c1[0], 1'b0);
    chk("t4.reload_w1", words[0][1], 18'h00003);
    chk("t4.reload_cnt", wr_cnt[0], 4);

    // Reset after the second shift pulse aborts the sequence.
    issue_load(1'b0, 2'd0, 18'h0);
    watch(16, -1, 2);
    chk("t5.wr_cnt", wr_cnt[0], 2);
    chk("t5.upd_cnt", upd_cnt[0], 0);
    chk("t5.done_cnt", done_cnt[0], 0);
    chk("t5.zero_a", zero_ok[0], 1'b1);
    chk("t5.zero_b", zero_ok[1], 1'b1);
    chk("t5.zero_c", zero_ok[2], 1'b1);
    for (int k = 0; k < 4; k++) chk($sformatf("t5.dsp%0d", k), live[k], exp_live[k]);
    issue_load(1'b0, 2'd0, 18'h0);
    watch(16, -1, -1);
    for (int k = 0; k < 4; k++) chk($sformatf("t5.shadow_w%0d", k), words[0][k], 18'h0);

    // Out-of-range address on the 3-entry instance.
    cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_dat = 18'h11111;
    step();
    chk("t6.c_err", c_err, 1'b1);
    chk("t6.a_err", a_err, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cfg_addr = 2'(k); cfg_dat = 18'(k + 5);
      step();
    end
    cfg_wr = 1'b0;
    chk("t6.c_err_hold", c_err, 1'b1);
    issue_load(1'b0, 2'd0, 18'h0);
    watch(16, -1, -1);
    chk("t6.wr_cnt", wr_cnt[2], 3);
    chk("t6.word0", words[2][0], 18'h00007);
    chk("t6.word1", words[2][1], 18'h00006);
    chk("t6.word2", words[2][2], 18'h00005);
    chk("t6.upd_at", upd_at[2], 4);
    chk("t6.done_at", done_at[2], 5);
    chk("t6.busy_len", busy_len[2], 5);
    chk("t6.err_c1", err_c1[2], 1'b0);
    chk("t6.a_word0", words[0][0], 18'h11111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/biquad_coeff_loader.md
Name: biquad_coeff_loader

Overview:
Writer side of the biquad DSP coefficient-load interface (coeff_dat/coeff_wr/coeff_update). It holds a host-written shadow copy of NCOEFF 18-bit coefficients. On a load command it shifts them into the DSP B-cascade chain, last index first, so that coefficient k lands in DSP k. It then issues a single update pulse so all new coefficients go live in the same cycle. It sits between the register/config bus and one biquad pole or zero section.

Parameters:
NCOEFF, 4, number of DSPs in the B-cascade chain (coeff_wr pulses per load); range 1..16
ADDRBITS, 2, width of cfg_addr_i; must be at least clog2(NCOEFF), minimum 1
WR_GAP, 0, idle cycles inserted between consecutive coeff_wr_o pulses; range 0..15

Ports:
clk  in  1  single clock; everything is synchronous to clk
rst  in  1  synchronous reset, active-high
cfg_wr_i  in  1  shadow write strobe
cfg_addr_i  in  ADDRBITS  shadow index
cfg_dat_i  in  18  signed coefficient value
cfg_load_i  in  1  start-load request, single-cycle strobe
cfg_busy_o  out  1  high while a load sequence is running
cfg_done_o  out  1  one-cycle pulse when a load completes
cfg_err_o  out  1  sticky error flag; cleared by rst or by the next accepted load
coeff_dat_o  out  18  coefficient value to the DSP B input
coeff_wr_o  out  1  shift strobe (drives CEB1)
coeff_update_o  out  1  commit strobe (drives CEB2)

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0 on the next cycle.
  - Shadow entries clear to 0.
  - FSM returns to IDLE.
- Reset mid-sequence:
  - Aborts the load immediately; no further coeff_wr_o pulses, no coeff_update_o, no cfg_done_o.
  - The DSP live (B2) coefficients are left unchanged.
- All outputs are registered.
- FSM states: IDLE, SHIFT, GAP, UPDATE, DONE.
- IDLE:
  - cfg_wr_i with cfg_addr_i < NCOEFF writes shadow[addr].
  - cfg_wr_i with cfg_addr_i >= NCOEFF is dropped and sets cfg_err_o.
  - cfg_load_i moves to SHIFT, clears cfg_err_o, and loads idx = NCOEFF-1.
- Same-cycle cfg_wr_i and cfg_load_i in IDLE: the write takes effect first and the load transmits the new value.
- SHIFT:
  - Drives coeff_wr_o=1 and coeff_dat_o=shadow[idx] for exactly one cycle.
  - If idx=0, go to UPDATE.
  - Otherwise decrement idx; go to GAP if WR_GAP>0, else stay in SHIFT.
- GAP: coeff_wr_o=0 for WR_GAP cycles, then return to SHIFT.
- UPDATE: coeff_update_o=1 for one cycle, then go to DONE.
- DONE: cfg_done_o=1 for one cycle, then go to IDLE.
- coeff_dat_o holds its last value whenever coeff_wr_o=0.
- Timing with a load accepted at cycle T and WR_GAP=0:
  - coeff_wr_o is high on T+1..T+NCOEFF.
  - coeff_update_o is high on T+NCOEFF+1.
  - cfg_done_o is high on T+NCOEFF+2.
  - cfg_busy_o is high on T+1..T+NCOEFF+2 and low on the cycle after done.
- General timing: coeff_wr_o pulses are spaced WR_GAP+1 cycles apart; total busy length is NCOEFF + (NCOEFF-1)*WR_GAP + 2 cycles.
- While busy:
  - cfg_wr_i is dropped (shadow is not modified) and sets cfg_err_o.
  - cfg_load_i is ignored and sets cfg_err_o.
  - Shadow is therefore stable for the whole sequence.
- coeff_dat_o is passed through as raw 18 bits with no arithmetic; sign and format are the host's responsibility.
- Gap counter is 4 bits, no wrap beyond WR_GAP. idx is clog2(NCOEFF) bits, minimum 1.

Decomposition:
- Shared header biquad_coeff_defs.vh holds:
  - COEFF_BITS=18
  - FSM state encodings (IDLE=0, SHIFT=1, GAP=2, UPDATE=3, DONE=4)
  - a macro for clog2
- One sub-module, biquad_coeff_shadow: NCOEFF x 18 register file with synchronous reset to 0, one write port, and a combinational read port indexed by idx.
- The FSM and gap counter stay in the top module.

Test Plan:
1. NCOEFF=4, WR_GAP=0: write shadow[0..3]=0x00001,0x00002,0x00003,0x3FFFF; pulse load at T -> coeff_dat_o = 0x3FFFF,3,2,1 on T+1..T+4 with coeff_wr_o=1; coeff_update_o=1 at T+5; cfg_done_o=1 at T+6; 4-deep shift-register model ends holding DSP0..3 = 1,2,3,0x3FFFF.
2. WR_GAP=2: same load -> coeff_wr_o high at T+1,T+4,T+7,T+10; update at T+11; done at T+12; busy for 12 cycles.
3. Same-cycle cfg_wr_i (addr 3, 0x12345) and cfg_load_i in IDLE -> first shifted word is 0x12345; cfg_err_o stays 0.
4. Write to addr 2 and a second load issued mid-sequence -> shadow unchanged; no extra coeff_wr_o pulses; cfg_err_o=1 until the next accepted load, which clears it.
5. rst asserted on the cycle after the second coeff_wr_o pulse -> outputs are 0 next cycle; coeff_update_o and cfg_done_o never pulse; shadow reads back 0.
6. Write with cfg_addr_i=3 when NCOEFF=3 -> write ignored, cfg_err_o=1; a following load shifts exactly 3 words.
